// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reaction_pkg
// Description : Shared state encoding, limits and LFSR helpers for the
//               reaction timer.
// Revision    : 1.0 - initial release
// ============================================================================
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        MEASURE = 3'd2,
        DONE    = 3'd3,
        FOUL    = 3'd4
    } state_t;

    localparam logic [13:0] MAX_TIME  = 14'd9999;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int          DELAY_W   = 17;

    // Fibonacci step for x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Fibonacci LFSR, reseeded on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/reaction_timer.sv
`default_nettype none
// ============================================================================
// Module      : reaction_timer
// Description : Random-delay stimulus, tick-based reaction measurement with
//               false-start detection and timeout saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int TICK_DIV        = 5000,
    parameter int DELAY_MIN       = 10000,
    parameter int DELAY_SPAN_LOG2 = 13
) (
    input  logic        clk,
    input  logic        en,
    input  logic        start,
    input  logic        resp,
    output logic        led,
    output logic [13:0] rectTime,
    output logic        valid,
    output logic        early,
    output logic        busy
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [15:0] SPAN_MASK = 16'((32'd1 << DELAY_SPAN_LOG2) - 32'd1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_start_d;
    logic                 r_resp_d;
    logic [PRESC_W-1:0]   r_presc;
    logic [DELAY_W-1:0]   r_delay;
    logic [13:0]          r_rect;
    logic                 r_led;
    logic                 r_valid;
    logic                 r_early;
    logic                 r_busy;

    logic [15:0]          w_lfsr;
    logic [15:0]          w_rand;
    logic [DELAY_W-1:0]   w_delay_load;
    logic [13:0]          w_rect_inc;
    logic                 w_start_rise;
    logic                 w_resp_rise;
    logic                 w_tick;
    logic                 w_load;
    logic                 w_dec;
    logic                 w_inc;
    logic                 w_presc_clr;

    lfsr16 u_lfsr (
        .clk (clk),
        .en  (en),
        .q   (w_lfsr)
    );

    assign w_start_rise = start & ~r_start_d;
    assign w_resp_rise  = resp & ~r_resp_d;
    assign w_tick       = (r_presc == PRESC_W'(TICK_DIV - 1));
    assign w_rand       = w_lfsr & SPAN_MASK;
    assign w_delay_load = DELAY_W'(DELAY_MIN) + DELAY_W'(w_rand);
    assign w_rect_inc   = r_rect + 14'd1;

    // Response beats start in the active states; start beats response elsewhere.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_inc       = 1'b0;
        w_presc_clr = 1'b0;
        case (r_state)
            IDLE, DONE, FOUL: begin
                if (w_start_rise) begin
                    w_next      = WAIT;
                    w_load      = 1'b1;
                    w_presc_clr = 1'b1;
                end
            end
            WAIT: begin
                if (w_resp_rise) begin
                    w_next = FOUL;
                end else if (w_tick) begin
                    if (r_delay == '0) begin
                        w_next      = MEASURE;
                        w_presc_clr = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            MEASURE: begin
                if (w_resp_rise) begin
                    w_next = DONE;
                end else if (w_tick) begin
                    w_inc = 1'b1;
                    if (w_rect_inc == MAX_TIME) begin
                        w_next = DONE;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            r_state   <= IDLE;
            r_start_d <= 1'b0;
            r_resp_d  <= 1'b0;
            r_presc   <= '0;
            r_delay   <= '0;
            r_rect    <= '0;
            r_led     <= 1'b0;
            r_valid   <= 1'b0;
            r_early   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_d <= start;
            r_resp_d  <= resp;

            if (w_presc_clr || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end

            if (w_load) begin
                r_delay <= w_delay_load;
            end else if (w_dec) begin
                r_delay <= r_delay - DELAY_W'(1);
            end

            if (w_load) begin
                r_rect <= '0;
            end else if (w_inc) begin
                r_rect <= w_rect_inc;
            end

            // Outputs decode the next state so they change on the transition edge.
            r_led   <= (w_next == MEASURE);
            r_valid <= (w_next == DONE);
            r_early <= (w_next == FOUL);
            r_busy  <= (w_next == WAIT) || (w_next == MEASURE);
        end
    end

    assign led      = r_led;
    assign rectTime = r_rect;
    assign valid    = r_valid;
    assign early    = r_early;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_timer
// Description : Scoreboard bench for reaction_timer with small tick/delay
//               parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_timer;

    localparam int TD   = 4;
    localparam int DMIN = 2;
    localparam int SPAN = 2;

    logic        clk   = 1'b0;
    logic        en    = 1'b0;
    logic        start = 1'b0;
    logic        resp  = 1'b0;
    logic        led;
    logic        valid;
    logic        early;
    logic        busy;
    logic [13:0] rectTime;

    always #5 clk = ~clk;

    reaction_timer #(
        .TICK_DIV        (TD),
        .DELAY_MIN       (DMIN),
        .DELAY_SPAN_LOG2 (SPAN)
    ) dut (
        .clk      (clk),
        .en       (en),
        .start    (start),
        .resp     (resp),
        .led      (led),
        .rectTime (rectTime),
        .valid    (valid),
        .early    (early),
        .busy     (busy)
    );

    typedef struct {
        bit foul;
        int rect;
        int wait_cyc;
        int led_hi;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference LFSR: value visible between edges is the one the next edge uses.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge en) begin
        if (!en) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // Monitor: pops one expectation per completed run (valid or early rising).
    int   tcyc = 0;
    int   busy_t = 0;
    int   led_t = 0;
    int   led_cnt = 0;
    bit   led_seen = 0;
    logic p_busy = 0, p_led = 0, p_valid = 0, p_early = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!en) begin
            led_seen = 0;
            led_cnt  = 0;
        end else begin
            if (busy && !p_busy) begin
                busy_t   = tcyc;
                led_seen = 0;
                led_cnt  = 0;
            end
            if (led && !p_led) begin
                led_t    = tcyc;
                led_seen = 1;
            end
            if (led) led_cnt++;
            if ((valid && !p_valid) || (early && !p_early)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_event", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ev_early", int'(early), int'(e.foul));
                    chk("ev_valid", int'(valid), int'(!e.foul));
                    chk("ev_rect", int'(rectTime), e.rect);
                    chk("ev_led_off", int'(led), 0);
                    chk("ev_busy_off", int'(busy), 0);
                    if (e.foul) begin
                        chk("foul_led_never", int'(led_seen), 0);
                    end else begin
                        chk("led_seen", int'(led_seen), 1);
                        chk("wait_interval", led_t - busy_t, e.wait_cyc);
                        chk("led_high_cycles", led_cnt, e.led_hi);
                    end
                end
            end
        end
        p_busy  = busy;
        p_led   = led;
        p_valid = valid;
        p_early = early;
        tcyc++;
    end

    // n = 0 means no response (timeout); otherwise resp is sampled n edges after led rises.
    task automatic run(input int n, input bit mid_start, input bit hold_start);
        exp_t e;
        int   g;
        int   d;
        d          = DMIN + int'(m_lfsr[1:0]);
        e.foul     = 0;
        e.wait_cyc = (d + 1) * TD;
        e.rect     = (n == 0) ? 9999 : (n - 1) / TD;
        e.led_hi   = (n == 0) ? 9999 * TD : n;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("rect_cleared", int'(rectTime), 0);
        g = 0;
        while (!led && g < 64) begin
            @(negedge clk);
            g++;
        end
        chk("led_rise_bound", int'(led), 1);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            if (mid_start && i == 1) start = 1'b1;
            if (mid_start && i == 2) begin
                start = 1'b0;
                chk("mid_start_led", int'(led), 1);
                chk("mid_start_busy", int'(busy), 1);
            end
        end
        if (n > 0) begin
            resp = 1'b1;
            @(negedge clk);
            resp = 1'b0;
        end
        g = 0;
        while (!valid && g < 45000) begin
            @(negedge clk);
            g++;
        end
        chk("done_bound", int'(valid), 1);
        if (hold_start) begin
            repeat (5) @(negedge clk);
            chk("held_start_valid", int'(valid), 1);
            chk("held_start_busy", int'(busy), 0);
            start = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   g;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_early", int'(early), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rect", int'(rectTime), 0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Normal run: response three ticks into the measurement
        run(13, 0, 0);

        // Restart from DONE straight into a false start
        e.foul = 1; e.rect = 0; e.wait_cyc = 0; e.led_hi = 0;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_valid", int'(valid), 0);
        chk("restart_rect", int'(rectTime), 0);
        chk("restart_busy", int'(busy), 1);
        resp = 1'b1;
        @(negedge clk);
        resp = 1'b0;
        chk("foul_early", int'(early), 1);
        repeat (3) @(negedge clk);

        // Start press inside MEASURE, then start held across DONE
        run(10, 1, 0);
        run(6, 0, 1);

        // Wait range sweep
        for (int i = 0; i < 32; i++) run(1 + (i % 11), 0, 0);

        // Asynchronous reset mid-measure
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (!led && g < 64) begin
            @(negedge clk);
            g++;
        end
        chk("ar_led_rise", int'(led), 1);
        repeat (6) @(negedge clk);
        chk("ar_pre_rect", int'(rectTime), 1);
        @(posedge clk);
        #2 en = 1'b0;
        #1;
        chk("ar_led", int'(led), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_valid", int'(valid), 0);
        chk("ar_early", int'(early), 0);
        chk("ar_rect", int'(rectTime), 0);
        @(negedge clk);
        en = 1'b1;
        repeat (10) @(negedge clk);
        chk("ar_idle_busy", int'(busy), 0);
        chk("ar_idle_valid", int'(valid), 0);
        run(5, 0, 0);

        // Timeout saturation
        run(0, 0, 0);
        repeat (20) @(negedge clk);
        chk("timeout_no_wrap", int'(rectTime), 9999);
        chk("timeout_valid_hold", int'(valid), 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reaction_timer.md
# reaction_timer

Measures a user's reaction time and produces the 14-bit `rectTime` value that the seven-segment display driver renders. A start press arms a pseudo-random wait; when it expires the stimulus LED lights and the block counts ticks until the response press. The block then holds the result with `valid` high. A response press during the wait is flagged as a false start.

## Interface
Parameters:
- `TICK_DIV`, default 5000: clock cycles per time unit (0.1 ms at 50 MHz).
- `DELAY_MIN`, default 10000: minimum wait, in ticks.
- `DELAY_SPAN_LOG2`, default 13: random extra wait is `lfsr[DELAY_SPAN_LOG2-1:0]` ticks.

Ports:
- `clk`, input, 1: system clock.
- `en`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `start`, input, 1: start button, debounced and synchronous, active-high.
- `resp`, input, 1: response button, debounced and synchronous, active-high.
- `led`, output, 1: stimulus LED, high only in MEASURE.
- `rectTime`, output, 14: measured time in ticks, saturates at 9999.
- `valid`, output, 1: high in DONE.
- `early`, output, 1: high in FOUL (false start).
- `busy`, output, 1: high in WAIT or MEASURE.

## Operation
- Edge detection:
  - `start_rise = start & ~start_d` and `resp_rise = resp & ~resp_d`.
  - `start_d` and `resp_d` are registered copies of the inputs and reset to 0.
- Tick prescaler:
  - Counts 0 to `TICK_DIV-1`; `tick` is asserted at `TICK_DIV-1`.
  - Cleared to 0 on every entry to WAIT or MEASURE.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Seed 16'hACE1 on reset; advances every clock, free-running.
- States:
  - IDLE: on `start_rise`, go to WAIT. Load `delay = DELAY_MIN + lfsr[DELAY_SPAN_LOG2-1:0]` and clear `rectTime` to 0.
  - WAIT:
    - On `resp_rise`, go to FOUL.
    - Otherwise, on `tick`: if `delay == 0`, go to MEASURE; else decrement `delay`.
  - MEASURE:
    - On `resp_rise`, go to DONE; `rectTime` keeps its current value (not incremented that cycle).
    - Else on `tick`: increment `rectTime`. If the new value would be 9999, store 9999 and go to DONE (timeout).
  - DONE, FOUL: hold all outputs. On `start_rise`, behave as IDLE.
- `start_rise` in WAIT or MEASURE is ignored.
- Simultaneous `start_rise` and `resp_rise`:
  - In IDLE, DONE or FOUL, start wins.
  - In WAIT or MEASURE, resp wins.
- Width rules:
  - `delay` is 17 bits; sum computed unsigned, no overflow for the default parameters.
  - `rectTime` is unsigned 14 bits and never exceeds 9999.

## Timing
- Reset values: state IDLE; `led`, `valid`, `early`, `busy` all 0; `rectTime` 0; prescaler 0; `delay` 0.
- All outputs are registered and decoded from state on the same edge as the state transition. No combinational input-to-output path.
- Start latency: `start` high before edge k gives `busy` = 1 after edge k.
- Wait duration: WAIT to MEASURE takes `(delay+1)*TICK_DIV` cycles after entry.
- Response latency: `resp` high before edge k gives `valid` = 1 and `led` = 0 after edge k.
- Reset mid-operation: asynchronous return to IDLE with all outputs at reset values; no result retained.
- A held `resp` or `start` generates only one event; it must be released and pressed again.

## Structure
- Shared package `reaction_pkg` holds:
  - State encoding constants: IDLE=3'd0, WAIT=3'd1, MEASURE=3'd2, DONE=3'd3, FOUL=3'd4.
  - `MAX_TIME = 14'd9999`.
  - LFSR seed 16'hACE1.
- One sub-module, `lfsr16`: ports `clk`, `en`, `q[15:0]`.
- Top level holds the FSM, prescaler, edge detectors, `delay` and `rectTime` registers.

## Test plan
All scenarios use `TICK_DIV=4`, `DELAY_MIN=2`, `DELAY_SPAN_LOG2=2`.
- Normal run:
  - Stimulus: reset, `start` pulse, then a single `resp` press 3 ticks after `led` rises.
  - Response: `led` high for 12 to 13 cycles; `rectTime` = 3; `valid` = 1; `busy` = 0.
- False start:
  - Stimulus: `resp_rise` one cycle after entering WAIT.
  - Response: `early` = 1, `led` never rises, `rectTime` = 0.
- Timeout:
  - Stimulus: no `resp` after `led` rises.
  - Response: DONE after 9999 ticks with `rectTime` = 9999 and `valid` = 1; no wrap to 0.
- Wait range:
  - Stimulus: 32 start/response runs.
  - Response: every WAIT-to-MEASURE interval is between 12 and 24 cycles; the `delay` load matches the LFSR reference model.
- Ignored events and restart:
  - `start_rise` during MEASURE changes nothing.
  - `start_rise` in DONE returns to WAIT, with `valid` = 0 and `rectTime` = 0 on the next edge.
  - `start` held high across DONE does not restart.
- Async reset:
  - Stimulus: drop `en` mid-MEASURE, between clock edges.
  - Response: outputs return to reset values immediately; after `en` is released the block stays in IDLE until a new `start_rise`.
